// File: rtl/biquad_inverse_filter_if.sv
// biquad_inverse_filter_if: sample-in / result-out valid-ready streams
// master: producer of y_in and consumer of x_out (testbench or upstream logic)
// slave : the inverse filter itself
interface biquad_inverse_filter_if;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] y_in;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] x_out;
  logic              sat;
  modport master (output in_valid, y_in, out_ready, input in_ready, out_valid, x_out, sat);
  modport slave  (input in_valid, y_in, out_ready, output in_ready, out_valid, x_out, sat);
endinterface

// File: rtl/biquad_inverse_filter.sv
// biquad_inverse_filter: recovers x[k] = (y[k+1] - A*y[k]) * B_INV >>> FRAC from a first-order recursive section
// clk     : rising-edge clock
// rst_n   : asynchronous active-low reset
// i_flush : synchronous history clear and abort of the in-flight sample
// bus     : in_valid/in_ready/y_in sample stream, out_valid/out_ready/x_out/sat result stream
module biquad_inverse_filter #(
  parameter logic signed [7:0] A     = 8'sd10,
  parameter logic signed [7:0] B_INV = 8'sd26,
  parameter int                FRAC  = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  biquad_inverse_filter_if.slave     bus
);
  typedef enum logic [1:0] {IDLE, MUL_A, MUL_B, OUT} state_t;
  state_t             r_state, w_next;
  logic signed [7:0]  r_y_prev, r_y_cur, r_x_out;
  logic signed [16:0] r_acc, w_op_a;
  logic signed [7:0]  w_op_b;
  logic signed [24:0] w_prod, w_r;
  logic               r_sat, w_hi, w_lo;
  // one shared multiplier: A*y_prev in MUL_A, acc*B_INV otherwise
  assign w_op_a = (r_state == MUL_A) ? 17'(r_y_prev) : r_acc;
  assign w_op_b = (r_state == MUL_A) ? A : B_INV;
  assign w_prod = 25'(w_op_a) * 25'(w_op_b);
  assign w_r    = w_prod >>> FRAC;
  assign w_hi   = w_r > 25'sd127;
  assign w_lo   = w_r < -25'sd128;
  assign bus.in_ready  = r_state == IDLE;
  assign bus.out_valid = r_state == OUT;
  assign bus.x_out     = r_x_out;
  assign bus.sat       = r_sat;
  always_comb begin
    w_next = r_state;
    w_next = i_flush ? IDLE :
             r_state == IDLE  ? (bus.in_valid ? MUL_A : IDLE) :
             r_state == MUL_A ? MUL_B :
             r_state == MUL_B ? OUT :
             (bus.out_ready ? IDLE : OUT);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_y_prev <= '0;
      r_y_cur  <= '0;
      r_acc    <= '0;
      r_x_out  <= '0;
      r_sat    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (i_flush) r_y_prev <= '0;
      else begin
        if (r_state == IDLE && bus.in_valid) r_y_cur <= bus.y_in;
        if (r_state == MUL_A) r_acc <= 17'(r_y_cur) - w_prod[16:0];
        if (r_state == MUL_B) begin
          r_x_out  <= w_hi ? 8'h7f : w_lo ? 8'h80 : w_r[7:0];
          r_sat    <= w_hi | w_lo;
          r_y_prev <= r_y_cur;
        end
      end
    end
  end
endmodule

// File: tb/tb_biquad_inverse_filter.sv
// tb_biquad_inverse_filter: table, hand-written and random checks against an arithmetic reference model
module tb_biquad_inverse_filter;
  localparam int A = 10, B_INV = 26, FRAC = 7;
  logic clk = 0, rst_n = 0, flush = 0;
  int checks = 0, errors = 0, m_prev = 0;
  biquad_inverse_filter_if bus ();
  biquad_inverse_filter #(.A(8'(A)), .B_INV(8'(B_INV)), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct { bit rst; int y; int x; int s; } vec_t;
  vec_t tbl[6];
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask
  // floor((y - A*yp) * B_INV / 2^FRAC), clipped to 8-bit signed
  task automatic model(input int y, input int yp, output int x, output int s);
    int p, d, q;
    p = (y - A * yp) * B_INV;
    d = 1 << FRAC;
    q = p / d;
    if (p % d != 0 && p < 0) q--;
    s = (q > 127 || q < -128) ? 1 : 0;
    x = q > 127 ? 127 : q < -128 ? -128 : q;
  endtask
  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_x_out", int'(bus.x_out), 0);
    chk("rst_sat", int'(bus.sat), 0);
    @(negedge clk);
    rst_n = 1;
    m_prev = 0;
  endtask
  // called at a negedge in IDLE; returns at the negedge after the accept edge
  task automatic accept(input int y, output int ex, output int es);
    bus.in_valid = 1;
    bus.y_in = 8'(y);
    chk("accept_in_ready", int'(bus.in_ready), 1);
    model(y, m_prev, ex, es);
    m_prev = y;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 0;
  endtask
  task automatic collect(input int ex, input int es, input int hold);
    int lat = 0;
    while (!bus.out_valid && lat < 10) begin
      chk("busy_in_ready", int'(bus.in_ready), 0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 2);
    chk("x_out", int'(bus.x_out), ex);
    chk("sat", int'(bus.sat), es);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1;
      bus.y_in = 8'($urandom);
      @(negedge clk);
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_in_ready", int'(bus.in_ready), 0);
      chk("hold_x_out", int'(bus.x_out), ex);
      chk("hold_sat", int'(bus.sat), es);
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 0;
    chk("post_hs_valid", int'(bus.out_valid), 0);
    chk("post_hs_in_ready", int'(bus.in_ready), 1);
  endtask
  initial begin
    int ex, es;
    tbl[0] = '{1, 50, 10, 0};
    tbl[1] = '{0, 60, -90, 0};
    tbl[2] = '{1, -128, -26, 0};
    tbl[3] = '{0, 127, 127, 1};
    tbl[4] = '{1, 127, 25, 0};
    tbl[5] = '{0, -128, -128, 1};
    bus.in_valid = 0;
    bus.y_in = '0;
    bus.out_ready = 0;
    @(negedge clk);
    do_reset();
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      accept(tbl[i].y, ex, es);
      collect(tbl[i].x, tbl[i].s, 0);
    end
    // async reset in the middle of MUL_B
    accept(77, ex, es);
    @(posedge clk);
    #2;
    do_reset();
    accept(50, ex, es);
    collect(10, 0, 0);
    // backpressure for 6 cycles, then accept on the edge right after the handshake
    accept(-40, ex, es);
    collect(ex, es, 6);
    accept(33, ex, es);
    collect(ex, es, 0);
    // flush during MUL_A abandons the sample and clears history
    accept(90, ex, es);
    flush = 1;
    @(posedge clk);
    @(negedge clk);
    flush = 0;
    m_prev = 0;
    for (int i = 0; i < 4; i++) begin
      chk("flushA_no_valid", int'(bus.out_valid), 0);
      @(negedge clk);
    end
    accept(50, ex, es);
    collect(10, 0, 0);
    // flush during OUT drops out_valid
    accept(-70, ex, es);
    @(negedge clk);
    @(negedge clk);
    chk("flushO_valid_before", int'(bus.out_valid), 1);
    flush = 1;
    @(posedge clk);
    @(negedge clk);
    flush = 0;
    m_prev = 0;
    chk("flushO_valid_after", int'(bus.out_valid), 0);
    chk("flushO_in_ready", int'(bus.in_ready), 1);
    // flush in IDLE with in_valid must not accept
    flush = 1;
    bus.in_valid = 1;
    bus.y_in = 8'sd99;
    @(posedge clk);
    @(negedge clk);
    flush = 0;
    bus.in_valid = 0;
    chk("flush_no_accept", int'(bus.in_ready), 1);
    accept(50, ex, es);
    collect(10, 0, 0);
    // random stream against the model
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        flush = 1;
        @(posedge clk);
        @(negedge clk);
        flush = 0;
        m_prev = 0;
      end
      accept(int'($urandom_range(0, 255)) - 128, ex, es);
      collect(ex, es, int'($urandom_range(0, 3)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
